// File: rtl/spi_ram_ctrl_if.sv
// Command/response bundle between the SPI slave shifter, the RAM controller and the MISO serialiser.
// din carries {opcode, payload}; the rx side is valid/ready and the tx side is valid/ready.
interface spi_ram_ctrl_if #(
  parameter int DATA_W = 8
);
  logic [DATA_W+1:0] din;
  logic              rx_valid;
  logic              rx_ready;
  logic [DATA_W-1:0] dout;
  logic              tx_valid;
  logic              tx_ready;
  logic              addr_err;

  modport master (
    output din, rx_valid, tx_ready,
    input  rx_ready, dout, tx_valid, addr_err
  );

  modport slave (
    input  din, rx_valid, tx_ready,
    output rx_ready, dout, tx_valid, addr_err
  );
endinterface

// File: rtl/spi_ram_ctrl.sv
// Command-decoded RAM behind the SPI slave: read data 1 cycle after an accepted read, held until tx_ready;
// rx_ready drops while a response is stalled. SPI_RAM_AUTO_INC_EN enables pointer auto-increment for bursts.
module spi_ram_ctrl #(
  parameter int DATA_W    = 8,
  parameter int ADDR_W    = 8,
  parameter int MEM_DEPTH = 256
) (
  input  logic           clk,
  input  logic           rst_n,
  spi_ram_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    OP_SET_WA = 2'b00,
    OP_WRITE  = 2'b01,
    OP_SET_RA = 2'b10,
    OP_READ   = 2'b11
  } op_e;

  typedef struct packed {
    op_e               op;
    logic [DATA_W-1:0] payload;
  } cmd_t;

  // One extra bit so MEM_DEPTH == 2**DATA_W is still representable.
  localparam logic [DATA_W:0] DEPTH_C = (DATA_W+1)'(MEM_DEPTH);

`ifdef SPI_RAM_AUTO_INC_EN
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  // Explicit wrap so non-power-of-2 depths roll over at MEM_DEPTH-1.
  function automatic logic [ADDR_W-1:0] bump(input logic [ADDR_W-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDR_W'(1);
  endfunction
`endif

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  cmd_t              cmd;
  logic              accept;
  logic              in_range;
  logic              mem_we;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] dout_q, dout_d;
  logic              tx_valid_q, tx_valid_d;
  logic              err_q, err_d;

  assign cmd          = cmd_t'(bus.din);
  assign bus.rx_ready = !tx_valid_q || bus.tx_ready;
  assign accept       = bus.rx_valid && bus.rx_ready;
  assign in_range     = {1'b0, cmd.payload} < DEPTH_C;

  assign bus.dout     = dout_q;
  assign bus.tx_valid = tx_valid_q;
  assign bus.addr_err = err_q;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    dout_d     = dout_q;
    tx_valid_d = tx_valid_q;
    err_d      = err_q;
    mem_we     = 1'b0;

    if (tx_valid_q && bus.tx_ready) begin
      tx_valid_d = 1'b0;
    end

    if (accept) begin
      case (cmd.op)
        OP_SET_WA: begin
          if (in_range) wr_ptr_d = cmd.payload[ADDR_W-1:0];
          else          err_d    = 1'b1;
        end
        OP_WRITE: begin
          mem_we = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
          wr_ptr_d = bump(wr_ptr_q);
`endif
        end
        OP_SET_RA: begin
          if (in_range) rd_ptr_d = cmd.payload[ADDR_W-1:0];
          else          err_d    = 1'b1;
        end
        OP_READ: begin
          // A read in the handshake cycle overrides the clear above: back-to-back words.
          dout_d     = mem[rd_ptr_q];
          tx_valid_d = 1'b1;
`ifdef SPI_RAM_AUTO_INC_EN
          rd_ptr_d = bump(rd_ptr_q);
`endif
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      dout_q     <= '0;
      tx_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      dout_q     <= dout_d;
      tx_valid_q <= tx_valid_d;
      err_q      <= err_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[wr_ptr_q] <= cmd.payload;
    end
  end

endmodule
